// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - op encodings presented on the op input
//   - FSM state encoding
//   - iteration count (one result bit per cycle)
package mdu_pkg;

  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MUL    = 2'b01,
    DIV    = 2'b10,
    FINISH = 2'b11
  } state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control path and the multiply/divide unit.
//   start, op, operand_a, operand_b : launch an operation (sampled in IDLE only)
//   hi_we, lo_we, move_data         : MTHI/MTLO writes (honoured in IDLE only)
//   hi, lo                          : architectural HI/LO registers
//   busy, done, div_by_zero         : status; done/div_by_zero are 1-cycle pulses
// master = control path side, slave = the unit itself.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] move_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, operand_a, operand_b, hi_we, lo_we, move_data,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, hi_we, lo_we, move_data,
    output hi, lo, busy, done, div_by_zero
  );

endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation.
//   negate_i : 1 = output the negation of value_i, 0 = pass value_i through
//   value_i  : input word
//   result_o : value_i or -value_i (full WIDTH, wraps on the most negative value)
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             negate_i,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] result_o
);

  assign result_o = negate_i ? (-value_i) : value_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU).
//   clock   : system clock, all state on posedge
//   reset_n : asynchronous active-low reset, aborts any operation in flight
//   bus     : slave side of mult_div_unit_if (request, move writes, HI/LO, status)
// Operations run on unsigned magnitudes (shift-add multiply, restoring divide,
// one bit per cycle) and the signs are applied when the result is committed.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = ITER_COUNT
) (
  input  logic               clock,
  input  logic               reset_n,
  mult_div_unit_if.slave     bus
);

  localparam int CntW = $clog2(WIDTH);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 is_div_q, is_div_d;
  logic                 zero_div_q, zero_div_d;
  logic                 res_neg_q, res_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                 signed_op;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   prod_fixed;
  logic [WIDTH-1:0]     quo_fixed, rem_fixed;
  logic                 last_iter;

  assign signed_op = ~bus.op[0];

  // Operand magnitudes, taken straight from the request inputs at accept time.
  mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
    .negate_i (signed_op & bus.operand_a[WIDTH-1]),
    .value_i  (bus.operand_a),
    .result_o (a_mag)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
    .negate_i (signed_op & bus.operand_b[WIDTH-1]),
    .value_i  (bus.operand_b),
    .result_o (b_mag)
  );

  // Result sign correction applied in FINISH.
  mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .negate_i (res_neg_q),
    .value_i  (acc_q),
    .result_o (prod_fixed)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .negate_i (res_neg_q),
    .value_i  (acc_q[WIDTH-1:0]),
    .result_o (quo_fixed)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .negate_i (rem_neg_q),
    .value_i  (rem_q),
    .result_o (rem_fixed)
  );

  // Multiply step: the multiplier sits in the low half of acc and is shifted
  // out as the product is shifted in from the top, carry included.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

  // Divide step: dividend bits leave the top of acc[WIDTH-1:0] into the
  // partial remainder while quotient bits enter at the bottom.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  assign last_iter = (cnt_q == CntW'(WIDTH - 1));

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    zero_div_d = zero_div_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.move_data;
        if (bus.lo_we) lo_d = bus.move_data;
        if (bus.start) begin
          cnt_d      = '0;
          is_div_d   = bus.op[1];
          res_neg_d  = signed_op & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
          rem_neg_d  = signed_op & bus.operand_a[WIDTH-1];
          zero_div_d = 1'b0;
          rem_d      = '0;
          if (!bus.op[1]) begin
            state_d = MUL;
            opnd_d  = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
          end else if (bus.operand_b == '0) begin
            state_d    = FINISH;
            zero_div_d = 1'b1;
          end else begin
            state_d = DIV;
            opnd_d  = b_mag;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
          end
        end
      end

      MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last_iter) state_d = FINISH;
      end

      DIV: begin
        rem_d             = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
        acc_d[WIDTH-1:0]  = {acc_q[WIDTH-2:0], ~div_trial[WIDTH]};
        cnt_d             = cnt_q + 1'b1;
        if (last_iter) state_d = FINISH;
      end

      FINISH: begin
        done_d  = 1'b1;
        dbz_d   = zero_div_q;
        state_d = IDLE;
        if (!zero_div_q) begin
          if (is_div_q) begin
            lo_d = quo_fixed;
            hi_d = rem_fixed;
          end else begin
            hi_d = prod_fixed[2*WIDTH-1:WIDTH];
            lo_d = prod_fixed[WIDTH-1:0];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      zero_div_q <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      zero_div_q <= zero_div_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: a table of operations with
// hand-computed HI/LO results, followed by sequences for reset abort,
// start-while-busy, divide by zero and MTHI/MTLO interaction.
module tb_mult_div_unit;

  logic clock;
  logic reset_n;
  int   checkCount;
  int   failCount;
  int   edgeCount;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs [11];

  // Advance one clock and settle 1 ns past the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present a request and clock it in (edge E0).
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  // Count edges from E0 (inclusive) until done is seen, bounded.
  task automatic waitDone(input int alreadyEdges, output int edges);
    edges = alreadyEdges;
    while (bus.done !== 1'b1 && edges < 60) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    checkCount    = 0;
    failCount     = 0;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.hi_we     = 1'b0;
    bus.lo_we     = 1'b0;
    bus.move_data = '0;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[5]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[6]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[10] = '{2'b00, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000};

    #12;
    checkOutput("reset_hi",   {32'h0, bus.hi}, 64'h0);
    checkOutput("reset_lo",   {32'h0, bus.lo}, 64'h0);
    checkOutput("reset_busy", {63'h0, bus.busy}, 64'h0);
    checkOutput("reset_done", {63'h0, bus.done}, 64'h0);
    checkOutput("reset_dbz",  {63'h0, bus.div_by_zero}, 64'h0);
    reset_n = 1'b1;
    tick();

    // Table-driven operations.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d_busy_e0", i), {63'h0, bus.busy}, 64'h1);
      waitDone(1, edgeCount);
      checkOutput($sformatf("vec%0d_latency", i), 64'(edgeCount), 64'd34);
      checkOutput($sformatf("vec%0d_hi", i), {32'h0, bus.hi}, {32'h0, vecs[i].expHi});
      checkOutput($sformatf("vec%0d_lo", i), {32'h0, bus.lo}, {32'h0, vecs[i].expLo});
      checkOutput($sformatf("vec%0d_busy_done", i), {63'h0, bus.busy}, 64'h0);
      checkOutput($sformatf("vec%0d_dbz", i), {63'h0, bus.div_by_zero}, 64'h0);
      tick();
      checkOutput($sformatf("vec%0d_done_pulse", i), {63'h0, bus.done}, 64'h0);
    end

    // Reset in the middle of a multiply aborts it and clears HI/LO.
    applyStimulus(2'b01, 32'd9, 32'd9);
    for (int c = 1; c < 10; c++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_hi",   {32'h0, bus.hi}, 64'h0);
    checkOutput("midrst_lo",   {32'h0, bus.lo}, 64'h0);
    checkOutput("midrst_busy", {63'h0, bus.busy}, 64'h0);
    #2;
    reset_n = 1'b1;
    tick();
    applyStimulus(2'b01, 32'd2, 32'd3);
    waitDone(1, edgeCount);
    checkOutput("postrst_latency", 64'(edgeCount), 64'd34);
    checkOutput("postrst_lo", {32'h0, bus.lo}, 64'd6);
    checkOutput("postrst_hi", {32'h0, bus.hi}, 64'd0);
    tick();

    // A start pulse in the middle of MULT -3 x 7 is ignored, as are operand changes.
    applyStimulus(2'b00, 32'hFFFFFFFD, 32'd7);
    for (int c = 1; c < 5; c++) tick();
    bus.op        = 2'b11;
    bus.operand_a = 32'd1;
    bus.operand_b = 32'd1;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    waitDone(6, edgeCount);
    checkOutput("busystart_latency", 64'(edgeCount), 64'd34);
    checkOutput("busystart_hi", {32'h0, bus.hi}, 64'hFFFFFFFF);
    checkOutput("busystart_lo", {32'h0, bus.lo}, 64'hFFFFFFEB);
    tick();
    checkOutput("busystart_idle", {63'h0, bus.busy}, 64'h0);

    // Preload HI/LO, then DIVU 100 / 0.
    bus.hi_we     = 1'b1;
    bus.move_data = 32'h11;
    tick();
    bus.hi_we     = 1'b0;
    bus.lo_we     = 1'b1;
    bus.move_data = 32'h22;
    tick();
    bus.lo_we     = 1'b0;
    checkOutput("preload_hi", {32'h0, bus.hi}, 64'h11);
    checkOutput("preload_lo", {32'h0, bus.lo}, 64'h22);
    applyStimulus(2'b11, 32'd100, 32'd0);
    checkOutput("dbz_busy_e0", {63'h0, bus.busy}, 64'h1);
    checkOutput("dbz_done_e0", {63'h0, bus.done}, 64'h0);
    tick();
    checkOutput("dbz_done_e1", {63'h0, bus.done}, 64'h1);
    checkOutput("dbz_flag_e1", {63'h0, bus.div_by_zero}, 64'h1);
    checkOutput("dbz_busy_e1", {63'h0, bus.busy}, 64'h0);
    checkOutput("dbz_hi", {32'h0, bus.hi}, 64'h11);
    checkOutput("dbz_lo", {32'h0, bus.lo}, 64'h22);
    tick();
    checkOutput("dbz_done_clr", {63'h0, bus.done}, 64'h0);
    checkOutput("dbz_flag_clr", {63'h0, bus.div_by_zero}, 64'h0);

    // MTLO while busy is dropped; MTHI in IDLE lands on the next edge.
    applyStimulus(2'b01, 32'd3, 32'd5);
    tick();
    bus.lo_we     = 1'b1;
    bus.move_data = 32'h1234;
    tick();
    bus.lo_we     = 1'b0;
    checkOutput("busy_mtlo_lo", {32'h0, bus.lo}, 64'h22);
    waitDone(3, edgeCount);
    checkOutput("mtlo_op_latency", 64'(edgeCount), 64'd34);
    checkOutput("mtlo_op_lo", {32'h0, bus.lo}, 64'd15);
    bus.hi_we     = 1'b1;
    bus.move_data = 32'hABCD;
    tick();
    bus.hi_we     = 1'b0;
    checkOutput("mthi_hi", {32'h0, bus.hi}, 64'hABCD);
    checkOutput("mthi_lo_held", {32'h0, bus.lo}, 64'd15);

    // Move write on the same edge as an accepted start, later overwritten.
    bus.hi_we     = 1'b1;
    bus.move_data = 32'h77;
    applyStimulus(2'b01, 32'd2, 32'd2);
    bus.hi_we     = 1'b0;
    checkOutput("samedge_hi_e0", {32'h0, bus.hi}, 64'h77);
    waitDone(1, edgeCount);
    checkOutput("samedge_hi_final", {32'h0, bus.hi}, 64'h0);
    checkOutput("samedge_lo_final", {32'h0, bus.lo}, 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the MIPS core.
- Sits directly downstream of the register bank: consumes `read_data1`/`read_data2` as `operand_a`/`operand_b`.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the results in the architectural HI/LO registers.
- Exposes `busy` for the control path's stall logic and `hi`/`lo` for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  launch the operation selected by op; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_a  input  WIDTH  rs value (multiplicand / dividend).
- operand_b  input  WIDTH  rt value (multiplier / divisor).
- hi_we  input  1  MTHI write strobe.
- lo_we  input  1  MTLO write strobe.
- move_data  input  WIDTH  MTHI/MTLO data.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when a result is committed or a divide is rejected.
- div_by_zero  output  1  one-cycle pulse alongside done for a zero divisor.

Behaviour:
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, iteration counter=0. A reset mid-operation aborts it; no partial result is written.
- States:
  - IDLE -> MUL on start with op[1]=0.
  - IDLE -> DIV on start with op[1]=1 and operand_b!=0.
  - IDLE -> FINISH on start with a DIV/DIVU and operand_b==0.
  - MUL/DIV -> FINISH after WIDTH iterations.
  - FINISH -> IDLE.
- Accept edge E0 (start=1 in IDLE):
  - Latches operand magnitudes: absolute value for signed ops, raw value for unsigned ops.
  - Latches result signs: product sign = a^b; quotient sign = a^b; remainder sign = a.
  - busy=1 from E0 until the edge leaving FINISH.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator; iterations on E1..E32.
- DIV: restoring division, one quotient bit per cycle, WIDTH+1-bit partial remainder; iterations on E1..E32.
- FINISH (edge E33) commits the result:
  - MUL: sign-fixed 64-bit product, high half -> hi, low half -> lo.
  - DIV: sign-fixed quotient -> lo, remainder -> hi.
  - Sign fix is two's-complement negation of the full width.
  - done=1 for the cycle after E33; busy=0 after E33. Total latency: start to result visible = 34 edges.
- Divide by zero: FINISH reached at E1; hi/lo unchanged; done and div_by_zero pulse together for one cycle; busy high only between E0 and E1.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (magnitude-path wrap, no trap).
- start while busy: ignored; the operation in flight is unaffected.
- hi_we/lo_we:
  - In IDLE: write move_data on posedge.
  - While busy: ignored.
  - Same edge as an accepted start: the move write happens, and the later FINISH overwrites it.
- Operands are sampled only at E0; later changes to operand_a/operand_b have no effect.
- hi/lo change only on reset, FINISH, or an IDLE move write.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum (IDLE, MUL, DIV, FINISH);
  - constant ITER_COUNT=WIDTH.
- One natural sub-module: mdu_sign_fix, combinational conditional two's-complement negation. It is instantiated for operand magnitude extraction and for result correction.

Test Plan:
- Reset: assert reset_n=0 mid-MUL at cycle 10 -> hi=lo=0, busy=0 immediately; next start runs a full 34 edges normally.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done at edge 33, busy low after it.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; a start pulse at cycle 5 is ignored and the result is unchanged.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100 / 0 with hi=0x11, lo=0x22 preloaded via hi_we/lo_we -> done and div_by_zero pulse at E1, hi=0x11, lo=0x22.
- MTLO 0x1234 while busy is ignored; after done, MTHI 0xABCD in IDLE -> hi=0xABCD on the next edge, lo holds the operation result.
